rv64g_l1_vlsu_mshr_array: RTL and testbench

Non-blocking, parametrised miss-status array for the vector LSU in the L1 data cache.
- On a vector access with lane misses, it captures the unique cache lines in one cycle.
- It issues their refills to the cache controller through a valid/ready request channel, keeping up to MAX_OUTSTANDING refills in flight.
- Responses are tagged and may return out of order.
- When every captured line has a response, it tells the VLSU to replay, with error and partial-capture status. It also supports abort with drain.

---
 rtl/rv64g_l1_vlsu_mshr_array.sv | 191 +++++++++++++++++++
 tb/tb_rv64g_l1_vlsu_mshr_array.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv64g_l1_vlsu_mshr_array.sv
// Miss-status array for the vector LSU: captures the unique missing lines of one vector op,
// issues their refills with a bounded number in flight, and reports replay status when all return.
module rv64g_l1_vlsu_mshr_array #(
    parameter int NUM_LANES       = 8,
    parameter int ADDR_W          = 64,
    parameter int LINE_BYTES      = 64,
    parameter int MAX_MISSES      = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ID_W            = 3,
    parameter int CNT_W           = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          vlsu_req_i,
    input  logic [NUM_LANES-1:0]          lane_miss_i,
    input  logic [NUM_LANES*ADDR_W-1:0]   lane_addr_i,
    input  logic                          abort_i,
    output logic                          refill_req_valid_o,
    input  logic                          refill_req_ready_i,
    output logic [ADDR_W-1:0]             refill_req_addr_o,
    output logic [ID_W-1:0]               refill_req_id_o,
    input  logic                          refill_rsp_valid_i,
    input  logic [ID_W-1:0]               refill_rsp_id_i,
    input  logic                          refill_rsp_err_i,
    output logic                          busy_o,
    output logic                          replay_ready_o,
    output logic                          replay_err_o,
    output logic                          replay_partial_o,
    input  logic                          replay_ack_i,
    output logic [CNT_W-1:0]              miss_count_o,
    output logic [CNT_W-1:0]              outstanding_o
);
    localparam int OFF    = $clog2(LINE_BYTES);
    localparam int LINE_W = ADDR_W - OFF;
    localparam logic [CNT_W-1:0] MAX_M = CNT_W'(MAX_MISSES);
    localparam logic [CNT_W-1:0] MAX_O = CNT_W'(MAX_OUTSTANDING);

    // state   | meaning
    // S_IDLE  | waiting for a vector op with misses
    // S_ISSUE | issuing refills, collecting responses
    // S_DRAIN | aborted; waiting for in-flight refills to return
    // S_DONE  | all lines resolved; replay indication held until ack
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [LINE_W-1:0]     slot_q [MAX_MISSES];
    logic [LINE_W-1:0]     slot_d [MAX_MISSES];
    logic [MAX_MISSES-1:0] issued_q, issued_d, done_q, done_d;
    logic [CNT_W-1:0]      issue_ptr_q, issue_ptr_d;
    logic [CNT_W-1:0]      miss_count_q, miss_count_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic                  err_q, err_d, partial_q, partial_d;

    logic [LINE_W-1:0]     cap_line [MAX_MISSES];
    logic [CNT_W-1:0]      cap_cnt;
    logic                  cap_part;
    logic                  lane_off_unused;

    // In-order lane scan with deduplication against slots filled earlier in the same scan
    always_comb begin
        logic [LINE_W-1:0] ln;
        logic              hit;
        ln              = '0;
        hit             = 1'b0;
        cap_cnt         = '0;
        cap_part        = 1'b0;
        lane_off_unused = 1'b0;
        for (int i = 0; i < MAX_MISSES; i++) cap_line[i] = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            ln  = lane_addr_i[k*ADDR_W+OFF +: LINE_W];
            lane_off_unused = lane_off_unused ^ (^lane_addr_i[k*ADDR_W +: OFF]);
            hit = 1'b0;
            for (int j = 0; j < MAX_MISSES; j++)
                if ((CNT_W'(j) < cap_cnt) && (cap_line[j] == ln)) hit = 1'b1;
            if (lane_miss_i[k] && !hit) begin
                if (cap_cnt < MAX_M) begin
                    for (int j = 0; j < MAX_MISSES; j++)
                        if (CNT_W'(j) == cap_cnt) cap_line[j] = ln;
                    cap_cnt = cap_cnt + CNT_W'(1);
                end else begin
                    cap_part = 1'b1;
                end
            end
        end
    end

    logic [MAX_MISSES-1:0] rsp_vec, cap_mask, ptr_vec, rsp_hit_vec;
    logic [LINE_W-1:0]     ptr_line;
    logic                  rsp_hit, fire, all_done;

    always_comb begin
        rsp_vec  = '0;
        cap_mask = '0;
        ptr_vec  = '0;
        ptr_line = '0;
        for (int i = 0; i < MAX_MISSES; i++) begin
            rsp_vec[i]  = refill_rsp_valid_i && (refill_rsp_id_i == ID_W'(i));
            cap_mask[i] = CNT_W'(i) < miss_count_q;
            ptr_vec[i]  = CNT_W'(i) == issue_ptr_q;
            if (ptr_vec[i]) ptr_line = slot_q[i];
        end
    end

    assign rsp_hit_vec = (state_q == S_ISSUE || state_q == S_DRAIN) ? (rsp_vec & issued_q & ~done_q) : '0;
    assign rsp_hit     = |rsp_hit_vec;
    assign all_done    = &(done_q | rsp_hit_vec | ~cap_mask);

    assign refill_req_valid_o = (state_q == S_ISSUE) && (issue_ptr_q < miss_count_q) &&
                                (outstanding_q < MAX_O) && !abort_i;
    assign fire               = refill_req_valid_o && refill_req_ready_i;
    assign refill_req_addr_o  = {ptr_line, {OFF{1'b0}}};
    assign refill_req_id_o    = ID_W'(issue_ptr_q);

    assign busy_o           = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign replay_ready_o   = (state_q == S_DONE);
    assign replay_err_o     = (state_q == S_DONE) && err_q;
    assign replay_partial_o = (state_q == S_DONE) && partial_q;
    assign miss_count_o     = miss_count_q;
    assign outstanding_o    = outstanding_q;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        issued_d      = issued_q;
        done_d        = done_q | rsp_hit_vec;
        issue_ptr_d   = issue_ptr_q;
        miss_count_d  = miss_count_q;
        outstanding_d = outstanding_q + CNT_W'(fire) - CNT_W'(rsp_hit);
        err_d         = err_q | (rsp_hit && refill_rsp_err_i);
        partial_d     = partial_q;
        case (state_q)
            S_IDLE: begin
                if (vlsu_req_i && (|lane_miss_i)) begin
                    state_d       = S_ISSUE;
                    slot_d        = cap_line;
                    issued_d      = '0;
                    done_d        = '0;
                    issue_ptr_d   = '0;
                    miss_count_d  = cap_cnt;
                    outstanding_d = '0;
                    err_d         = 1'b0;
                    partial_d     = cap_part;
                end
            end
            S_ISSUE: begin
                if (fire) begin
                    issued_d    = issued_q | ptr_vec;
                    issue_ptr_d = issue_ptr_q + CNT_W'(1);
                end
                // Abort takes priority even over a completing response
                if (abort_i)       state_d = S_DRAIN;
                else if (all_done) state_d = S_DONE;
            end
            S_DRAIN: begin
                if (outstanding_d == '0) state_d = S_IDLE;
            end
            S_DONE: begin
                if (replay_ack_i || abort_i) begin
                    state_d   = S_IDLE;
                    err_d     = 1'b0;
                    partial_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            for (int i = 0; i < MAX_MISSES; i++) slot_q[i] <= '0;
            issued_q      <= '0;
            done_q        <= '0;
            issue_ptr_q   <= '0;
            miss_count_q  <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            partial_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            issued_q      <= issued_d;
            done_q        <= done_d;
            issue_ptr_q   <= issue_ptr_d;
            miss_count_q  <= miss_count_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            partial_q     <= partial_d;
        end
    end
endmodule

// File: tb/tb_rv64g_l1_vlsu_mshr_array.sv
// Scoreboard bench for the vector LSU miss-status array: expected refills are queued at capture
// and checked as the DUT issues them; replay/status outputs are checked per scenario.
module tb_rv64g_l1_vlsu_mshr_array;
    localparam int NL = 12;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              vlsu_req_i;
    logic [NL-1:0]     lane_miss_i;
    logic [NL*64-1:0]  lane_addr_i;
    logic              abort_i;
    logic              refill_req_valid_o;
    logic              refill_req_ready_i;
    logic [63:0]       refill_req_addr_o;
    logic [2:0]        refill_req_id_o;
    logic              refill_rsp_valid_i;
    logic [2:0]        refill_rsp_id_i;
    logic              refill_rsp_err_i;
    logic              busy_o;
    logic              replay_ready_o;
    logic              replay_err_o;
    logic              replay_partial_o;
    logic              replay_ack_i;
    logic [3:0]        miss_count_o;
    logic [3:0]        outstanding_o;

    logic [63:0] la [NL];

    typedef struct packed {
        logic [63:0] addr;
        logic [2:0]  id;
    } sb_t;

    sb_t        sb   [$];
    logic [2:0] pend [$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_cap;
    bit         part;

    for (genvar k = 0; k < NL; k++) begin : g_la
        assign lane_addr_i[k*64 +: 64] = la[k];
    end

    always #5 clk_i = ~clk_i;

    rv64g_l1_vlsu_mshr_array #(.NUM_LANES(NL)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .vlsu_req_i         (vlsu_req_i),
        .lane_miss_i        (lane_miss_i),
        .lane_addr_i        (lane_addr_i),
        .abort_i            (abort_i),
        .refill_req_valid_o (refill_req_valid_o),
        .refill_req_ready_i (refill_req_ready_i),
        .refill_req_addr_o  (refill_req_addr_o),
        .refill_req_id_o    (refill_req_id_o),
        .refill_rsp_valid_i (refill_rsp_valid_i),
        .refill_rsp_id_i    (refill_rsp_id_i),
        .refill_rsp_err_i   (refill_rsp_err_i),
        .busy_o             (busy_o),
        .replay_ready_o     (replay_ready_o),
        .replay_err_o       (replay_err_o),
        .replay_partial_o   (replay_partial_o),
        .replay_ack_i       (replay_ack_i),
        .miss_count_o       (miss_count_o),
        .outstanding_o      (outstanding_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every accepted request must match the next expected refill
    always @(negedge clk_i) begin
        if (!rst_i && refill_req_valid_o && refill_req_ready_i) begin
            chk("sb_has_entry", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                sb_t e;
                e = sb.pop_front();
                chk("req_addr", refill_req_addr_o, e.addr);
                chk("req_id", 64'(refill_req_id_o), 64'(e.id));
            end
            pend.push_back(refill_req_id_o);
        end
    end

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic fin();
        @(posedge clk_i);
        #1;
        vlsu_req_i         = 1'b0;
        lane_miss_i        = '0;
        abort_i            = 1'b0;
        replay_ack_i       = 1'b0;
        refill_rsp_valid_i = 1'b0;
        refill_rsp_id_i    = '0;
        refill_rsp_err_i   = 1'b0;
    endtask

    task automatic rsp(input logic [2:0] id, input logic err);
        refill_rsp_valid_i = 1'b1;
        refill_rsp_id_i    = id;
        refill_rsp_err_i   = err;
    endtask

    // Model of capture: unique lines in lane order, first 8 kept, the rest flag partial
    task automatic capture(input logic [NL-1:0] m, output int n, output bit pt);
        logic [63:0] lines [$];
        logic [63:0] ln;
        bit          found;
        sb_t         e;
        n  = 0;
        pt = 1'b0;
        pend.delete();
        for (int k = 0; k < NL; k++) begin
            if (m[k]) begin
                ln    = la[k] & ~64'h3F;
                found = 1'b0;
                foreach (lines[j]) if (lines[j] == ln) found = 1'b1;
                if (!found) begin
                    if (lines.size() < 8) begin
                        lines.push_back(ln);
                        e.addr = ln;
                        e.id   = 3'(n);
                        sb.push_back(e);
                        n++;
                    end else begin
                        pt = 1'b1;
                    end
                end
            end
        end
        vlsu_req_i  = 1'b1;
        lane_miss_i = m;
        mid();
        fin();
    endtask

    // Answers issued refills in issue order, one per cycle, with a bounded cycle budget
    task automatic serve(input int n, input int err_id);
        int got;
        logic [2:0] id;
        got = 0;
        for (int c = 0; c < 300 && got < n; c++) begin
            if (pend.size() > 0) begin
                id = pend.pop_front();
                rsp(id, 1'(int'(id) == err_id));
                got++;
            end
            mid();
            fin();
        end
        chk("serve_count", 64'(got), 64'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ord[3];
        rst_i              = 1'b1;
        vlsu_req_i         = 1'b0;
        lane_miss_i        = '0;
        abort_i            = 1'b0;
        refill_req_ready_i = 1'b0;
        refill_rsp_valid_i = 1'b0;
        refill_rsp_id_i    = '0;
        refill_rsp_err_i   = 1'b0;
        replay_ack_i       = 1'b0;
        for (int k = 0; k < NL; k++) la[k] = 64'hDEAD_0000 + 64'(k * 8);
        repeat (2) @(posedge clk_i);
        mid();
        chk("rst_valid", 64'(refill_req_valid_o), 64'd0);
        chk("rst_addr", refill_req_addr_o, 64'd0);
        chk("rst_id", 64'(refill_req_id_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_ready", 64'(replay_ready_o), 64'd0);
        chk("rst_err", 64'(replay_err_o), 64'd0);
        chk("rst_partial", 64'(replay_partial_o), 64'd0);
        chk("rst_miss_count", 64'(miss_count_o), 64'd0);
        chk("rst_outstanding", 64'(outstanding_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Single line shared by 8 lanes
        refill_req_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) la[k] = 64'h1000 + 64'(k * 8);
        capture(12'h0FF, n_cap, part);
        mid();
        chk("t1_valid_c1", 64'(refill_req_valid_o), 64'd1);
        chk("t1_miss_count", 64'(miss_count_o), 64'd1);
        chk("t1_busy", 64'(busy_o), 64'd1);
        fin();
        mid();
        chk("t1_outstanding", 64'(outstanding_o), 64'd1);
        chk("t1_valid_c2", 64'(refill_req_valid_o), 64'd0);
        fin();
        rsp(3'd0, 1'b0);
        mid();
        chk("t1_ready_at_r", 64'(replay_ready_o), 64'd0);
        fin();
        mid();
        chk("t1_ready_r1", 64'(replay_ready_o), 64'd1);
        chk("t1_err", 64'(replay_err_o), 64'd0);
        chk("t1_busy_done", 64'(busy_o), 64'd0);
        fin();
        replay_ack_i = 1'b1;
        mid();
        chk("t1_ready_ack", 64'(replay_ready_o), 64'd1);
        fin();
        mid();
        chk("t1_ready_idle", 64'(replay_ready_o), 64'd0);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);
        fin();

        // Out-of-order responses
        for (int k = 0; k < 4; k++) la[k] = 64'(k) * 64'h40;
        capture(12'h00F, n_cap, part);
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("t2_valid_burst", 64'(refill_req_valid_o), 64'd1);
            fin();
        end
        mid();
        chk("t2_outstanding", 64'(outstanding_o), 64'd4);
        chk("t2_valid_end", 64'(refill_req_valid_o), 64'd0);
        fin();
        ord = '{2, 0, 3};
        for (int i = 0; i < 3; i++) begin
            rsp(3'(ord[i]), 1'b0);
            mid();
            chk("t2_ready_early", 64'(replay_ready_o), 64'd0);
            fin();
        end
        rsp(3'd1, 1'b0);
        mid();
        chk("t2_outstanding_1", 64'(outstanding_o), 64'd1);
        fin();
        mid();
        chk("t2_ready", 64'(replay_ready_o), 64'd1);
        chk("t2_outstanding_0", 64'(outstanding_o), 64'd0);
        replay_ack_i = 1'b1;
        fin();
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);

        // Throttling at four in flight
        for (int k = 0; k < 6; k++) la[k] = 64'h2000 + 64'(k) * 64'h40;
        capture(12'h03F, n_cap, part);
        repeat (4) begin mid(); fin(); end
        mid();
        chk("t3_valid_full", 64'(refill_req_valid_o), 64'd0);
        chk("t3_out_full", 64'(outstanding_o), 64'd4);
        fin();
        rsp(3'd0, 1'b0);
        mid();
        chk("t3_valid_rsp_cycle", 64'(refill_req_valid_o), 64'd0);
        fin();
        rsp(3'd1, 1'b0);
        mid();
        chk("t3_valid_reopen", 64'(refill_req_valid_o), 64'd1);
        chk("t3_id4", 64'(refill_req_id_o), 64'd4);
        chk("t3_out_3", 64'(outstanding_o), 64'd3);
        fin();
        mid();
        chk("t3_out_simul", 64'(outstanding_o), 64'd3);
        chk("t3_id5", 64'(refill_req_id_o), 64'd5);
        fin();
        mid();
        chk("t3_out_4", 64'(outstanding_o), 64'd4);
        chk("t3_valid_exhausted", 64'(refill_req_valid_o), 64'd0);
        fin();
        for (int i = 2; i < 6; i++) begin rsp(3'(i), 1'b0); mid(); fin(); end
        mid();
        chk("t3_ready", 64'(replay_ready_o), 64'd1);
        chk("t3_miss_count", 64'(miss_count_o), 64'd6);
        replay_ack_i = 1'b1;
        fin();
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Overflow with duplicates, plus an error response on id 1
        for (int k = 0; k < 10; k++) la[k] = 64'h3000 + 64'(k) * 64'h40;
        la[10] = la[2] + 64'h8;
        la[11] = la[9] + 64'h10;
        capture(12'hFFF, n_cap, part);
        serve(8, 1);
        mid();
        chk("t4_ready", 64'(replay_ready_o), 64'd1);
        chk("t4_err", 64'(replay_err_o), 64'd1);
        chk("t4_partial", 64'(replay_partial_o), 64'(part));
        chk("t4_miss_count", 64'(miss_count_o), 64'(n_cap));
        replay_ack_i = 1'b1;
        fin();
        mid();
        chk("t4_ready_cleared", 64'(replay_ready_o), 64'd0);
        chk("t4_err_cleared", 64'(replay_err_o), 64'd0);
        fin();
        la[0] = 64'h4000;
        capture(12'h001, n_cap, part);
        serve(1, 99);
        mid();
        chk("t4b_ready", 64'(replay_ready_o), 64'd1);
        chk("t4b_err", 64'(replay_err_o), 64'd0);
        chk("t4b_partial", 64'(replay_partial_o), 64'd0);
        replay_ack_i = 1'b1;
        fin();
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);

        // Abort with drain
        for (int k = 0; k < 4; k++) la[k] = 64'h5000 + 64'(k) * 64'h40;
        capture(12'h00F, n_cap, part);
        mid(); fin();
        mid(); fin();
        refill_req_ready_i = 1'b0;
        mid();
        chk("t5_pending_valid", 64'(refill_req_valid_o), 64'd1);
        chk("t5_pending_id", 64'(refill_req_id_o), 64'd2);
        fin();
        abort_i = 1'b1;
        mid();
        chk("t5_abort_valid", 64'(refill_req_valid_o), 64'd0);
        chk("t5_abort_busy", 64'(busy_o), 64'd1);
        fin();
        sb.delete();
        refill_req_ready_i = 1'b1;
        mid();
        chk("t5_drain_valid", 64'(refill_req_valid_o), 64'd0);
        chk("t5_drain_out", 64'(outstanding_o), 64'd2);
        fin();
        rsp(3'd5, 1'b0);
        mid(); fin();
        rsp(3'd0, 1'b0);
        mid();
        chk("t5_stray_ignored", 64'(outstanding_o), 64'd2);
        chk("t5_drain_valid2", 64'(refill_req_valid_o), 64'd0);
        fin();
        rsp(3'd1, 1'b0);
        mid();
        chk("t5_busy_last", 64'(busy_o), 64'd1);
        chk("t5_out_1", 64'(outstanding_o), 64'd1);
        fin();
        mid();
        chk("t5_idle_busy", 64'(busy_o), 64'd0);
        chk("t5_no_replay", 64'(replay_ready_o), 64'd0);
        chk("t5_out_0", 64'(outstanding_o), 64'd0);
        fin();
        mid();
        chk("t5_no_replay2", 64'(replay_ready_o), 64'd0);
        fin();

        // Reset in the middle of issue
        for (int k = 0; k < 3; k++) la[k] = 64'h6000 + 64'(k) * 64'h40;
        capture(12'h007, n_cap, part);
        mid(); fin();
        mid();
        #2;
        rst_i = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(refill_req_valid_o), 64'd0);
        chk("t6_rst_busy", 64'(busy_o), 64'd0);
        chk("t6_rst_out", 64'(outstanding_o), 64'd0);
        chk("t6_rst_miss", 64'(miss_count_o), 64'd0);
        chk("t6_rst_addr", refill_req_addr_o, 64'd0);
        chk("t6_rst_id", 64'(refill_req_id_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        sb.delete();
        pend.delete();
        rsp(3'd0, 1'b0);
        mid(); fin();
        mid();
        chk("t6_late_rsp_out", 64'(outstanding_o), 64'd0);
        chk("t6_late_rsp_busy", 64'(busy_o), 64'd0);
        fin();
        la[0] = 64'h7040;
        la[1] = 64'h7078;
        capture(12'h003, n_cap, part);
        mid();
        chk("t6_new_valid", 64'(refill_req_valid_o), 64'd1);
        chk("t6_new_miss", 64'(miss_count_o), 64'd1);
        fin();
        serve(1, 99);
        mid();
        chk("t6_new_ready", 64'(replay_ready_o), 64'd1);
        replay_ack_i = 1'b1;
        fin();
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
